// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings, ASCII constants and helpers for the UART hex receiver
package uart_pkg;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {P_IDLE, P_ACCUM, P_DISCARD} p_state_t;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Returns {is_digit, nibble}; nibble is 0 when the character is not a hex digit
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return {1'b1, 4'(c - 8'h30)};
        if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c - 8'h37)};
        if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c - 8'h57)};
        return 5'd0;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 2-FF synchronizer plus 8N1 receive FSM sampling at bit centres
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1085
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    sync;
    logic          rxd;
    logic          tick;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    rx_state_t     state, next;

    assign rxd  = sync[1];
    assign tick = clk_cnt == (state == R_START ? HALF : FULL);

    // Bring the asynchronous line into the clock domain, idle high
    always_ff @(posedge clk)
        sync <= rst ? 2'b11 : {sync[0], uart_rxd};

    // State register
    always_ff @(posedge clk)
        state <= rst ? R_IDLE : next;

    // Next state: half-bit start qualification rejects short glitches
    always_comb begin
        next = state;
        case (state)
            R_IDLE:  if (!rxd) next = R_START;
            R_START: if (tick) next = rxd ? R_IDLE : R_DATA;
            R_DATA:  if (tick && bit_idx == 3'd7) next = R_STOP;
            R_STOP:  if (tick) next = R_IDLE;
            default: next = R_IDLE;
        endcase
    end

    // Baud counter restarts every sample point; data shifts in LSB first
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            rx_data <= 8'h00;
        end else begin
            clk_cnt <= (state == R_IDLE || tick) ? '0 : clk_cnt + 1'b1;
            if (state == R_DATA && tick) begin
                bit_idx <= bit_idx + 3'd1;
                rx_data <= {rxd, rx_data[7:1]};
            end
        end
    end

    // Outputs: stop bit judged at its centre, leaving half a bit of slack
    always_comb begin
        rx_valid  = state == R_STOP && tick && rxd;
        frame_err = state == R_STOP && tick && !rxd;
        rx_busy   = state != R_IDLE;
    end

endmodule

// File: rtl/uart_hex_rx.sv
// uart_hex_rx: parses CR/LF-terminated ASCII hex lines from UART into 32-bit words; UART_HEX_RX_ECHO_EN enables byte echo
module uart_hex_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 125000000,
    parameter int BAUD_RATE  = 115200,
    parameter int MAX_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rxd,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic        fmt_err,
    output logic        frame_err,
    output logic        rx_busy,
    output logic [7:0]  echo_data,
    output logic        echo_start
);
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ferr;
    logic [4:0]  dec;
    logic        is_term;
    logic        take_digit;
    logic        emit;
    logic        err;
    logic [31:0] acc;
    logic [3:0]  cnt;
    p_state_t    p_state, p_next;

    uart_rx #(.CLKS_PER_BIT(clks_per_bit(CLK_FREQ, BAUD_RATE))) u_rx (
        .clk      (clk),
        .rst      (rst),
        .uart_rxd (uart_rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(rx_ferr),
        .rx_busy  (rx_busy)
    );

`ifdef UART_HEX_RX_ECHO_EN
    assign echo_data  = rx_data;
    assign echo_start = rx_valid;
`else
    assign echo_data  = 8'h00;
    assign echo_start = 1'b0;
`endif

    assign dec     = hex_decode(rx_data);
    assign is_term = rx_data == CR || rx_data == LF;

    // Parser state register
    always_ff @(posedge clk)
        p_state <= rst ? P_IDLE : p_next;

    // Parser next state; a framing error poisons a partially built line
    always_comb begin
        p_next = p_state;
        if (rx_valid)
            case (p_state)
                P_IDLE:    p_next = dec[4] ? P_ACCUM : (is_term ? P_IDLE : P_DISCARD);
                P_ACCUM:   p_next = is_term ? P_IDLE : ((dec[4] && cnt < 4'(MAX_DIGITS)) ? P_ACCUM : P_DISCARD);
                P_DISCARD: p_next = is_term ? P_IDLE : P_DISCARD;
                default:   p_next = P_IDLE;
            endcase
        else if (rx_ferr && p_state == P_ACCUM)
            p_next = P_DISCARD;
    end

    // Parser actions for the byte just received
    always_comb begin
        take_digit = rx_valid && dec[4] && (p_state == P_IDLE || (p_state == P_ACCUM && cnt < 4'(MAX_DIGITS)));
        emit       = rx_valid && is_term && p_state == P_ACCUM;
        err        = rx_valid && p_state != P_DISCARD && !is_term && !take_digit;
    end

    // Accumulator and registered output pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= 32'h0;
            cnt        <= 4'd0;
            word_out   <= 32'h0;
            word_valid <= 1'b0;
            fmt_err    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            word_valid <= emit;
            fmt_err    <= err;
            frame_err  <= rx_ferr;
            if (take_digit) begin
                acc <= p_state == P_IDLE ? {28'h0, dec[3:0]} : {acc[27:0], dec[3:0]};
                cnt <= p_state == P_IDLE ? 4'd1 : cnt + 4'd1;
            end
            if (emit) word_out <= acc;
        end
    end

endmodule
